inst_loop_sequencer: RTL and testbench

- Program-counter sequencer for the instruction memory: issues instruction addresses and applies up to three nested hardware loops.
- Configured from the instruction loop CSRs: loop mode, jump/end address fields and count fields, each 8 bits wide at bit offsets 0/8/16.
- Sits between the CSR block and the instruction memory read port. Started by the core start bit, cleared by the core clear bit; drives the core busy status.

---
 rtl/inst_loop_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_inst_loop_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loop_sequencer.sv
// Instruction-loop program-counter sequencer.
//
// Issues instruction addresses to the instruction memory read port and applies up to
// NumLoops nested hardware loops (level 0 innermost). The loop configuration is captured
// when a program starts, so the CSR inputs may change freely while the sequencer runs.
//
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   start_i          start request, level-sampled while idle
//   clr_i            synchronous clear, overrides everything, no done pulse
//   loop_mode_i      active levels: 0 -> 1 level, 1 -> 2 levels, 2/3 -> 3 levels
//   jump_addr_i      per-level jump target, level k at [k*InstAddrWidth +: InstAddrWidth]
//   end_addr_i       per-level last instruction address
//   loop_count_i     per-level total iterations (0 behaves as 1)
//   inst_ready_i     downstream accepts the current address
//   inst_pc_o        current instruction address
//   inst_valid_o     inst_pc_o is valid
//   busy_o           sequencer running
//   done_o           one-cycle pulse on program completion
//   overrun_o        sticky: PC hit the top address without an outermost end match
module inst_loop_sequencer #(
    parameter int unsigned InstAddrWidth  = 8,
    parameter int unsigned LoopCountWidth = 8,
    parameter int unsigned NumLoops       = 3
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 start_i,
    input  logic                                 clr_i,
    input  logic [1:0]                           loop_mode_i,
    input  logic [NumLoops*InstAddrWidth-1:0]    jump_addr_i,
    input  logic [NumLoops*InstAddrWidth-1:0]    end_addr_i,
    input  logic [NumLoops*LoopCountWidth-1:0]   loop_count_i,
    input  logic                                 inst_ready_i,
    output logic [InstAddrWidth-1:0]             inst_pc_o,
    output logic                                 inst_valid_o,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 overrun_o
);

    localparam int Aw = int'(InstAddrWidth);
    localparam int Cw = int'(LoopCountWidth);
    localparam int Nl = int'(NumLoops);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                               state_q, state_d;
    logic [InstAddrWidth-1:0]             pc_q, pc_d;
    logic                                 valid_q, valid_d;
    logic                                 busy_q, busy_d;
    logic                                 done_q, done_d;
    logic                                 overrun_q, overrun_d;
    logic [NumLoops-1:0][LoopCountWidth-1:0] cnt_q, cnt_d;
    logic [1:0]                           mode_q, mode_d;
    logic [NumLoops*InstAddrWidth-1:0]    jump_q, jump_d;
    logic [NumLoops*InstAddrWidth-1:0]    end_q, end_d;
    logic [NumLoops*LoopCountWidth-1:0]   count_q, count_d;

    logic [NumLoops-1:0] match;
    logic [NumLoops-1:0] exhausted;
    logic                found;
    int                  sel;
    int                  outer;

    // A level is on its last iteration once the counter reaches max(count,1)-1.
    function automatic logic is_exhausted(input logic [LoopCountWidth-1:0] cnt,
                                          input logic [LoopCountWidth-1:0] count);
        logic [LoopCountWidth-1:0] lim;
        lim = (count == '0) ? '0 : count - 1'b1;
        return cnt >= lim;
    endfunction

    // Per-level end match and exhaustion; levels above the outermost active one never match.
    always_comb begin
        outer = (int'(mode_q) >= Nl - 1) ? Nl - 1 : int'(mode_q);
        match = '0;
        exhausted = '0;
        for (int k = 0; k < Nl; k++) begin
            match[k]     = (k <= outer) && (pc_q == end_q[k*Aw +: Aw]);
            exhausted[k] = is_exhausted(cnt_q[k], count_q[k*Cw +: Cw]);
        end
    end

    // Innermost matching level that still has iterations left takes the jump.
    always_comb begin
        found = 1'b0;
        sel   = 0;
        for (int k = 0; k < Nl; k++) begin
            if (match[k] && !exhausted[k] && !found) begin
                found = 1'b1;
                sel   = k;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        jump_d    = jump_q;
        end_d     = end_q;
        count_d   = count_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    mode_d    = loop_mode_i;
                    jump_d    = jump_addr_i;
                    end_d     = end_addr_i;
                    count_d   = loop_count_i;
                    pc_d      = '0;
                    cnt_d     = '0;
                    overrun_d = 1'b0;
                    state_d   = StRun;
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            StRun: begin
                valid_d = 1'b1;
                busy_d  = 1'b1;
                if (inst_ready_i) begin
                    if (found) begin
                        for (int j = 0; j < Nl; j++) begin
                            if (j < sel && match[j]) cnt_d[j] = '0;
                        end
                        cnt_d[sel] = cnt_q[sel] + 1'b1;
                        pc_d       = jump_q[sel*Aw +: Aw];
                    end else if (match[outer]) begin
                        cnt_d   = '0;
                        state_d = StDone;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        for (int j = 0; j < Nl; j++) begin
                            if (match[j]) cnt_d[j] = '0;
                        end
                        pc_d = pc_q + 1'b1;
                    end
                    // Top address without the program end: stop rather than wrap to 0.
                    if ((pc_q == {InstAddrWidth{1'b1}}) && !match[outer]) begin
                        pc_d      = pc_q;
                        overrun_d = 1'b1;
                        state_d   = StDone;
                        valid_d   = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (clr_i) begin
            state_d   = StIdle;
            pc_d      = '0;
            cnt_d     = '0;
            overrun_d = 1'b0;
            valid_d   = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            cnt_q     <= '0;
            mode_q    <= '0;
            jump_q    <= '0;
            end_q     <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            jump_q    <= jump_d;
            end_q     <= end_d;
            count_q   <= count_d;
        end
    end

    assign inst_pc_o    = pc_q;
    assign inst_valid_o = valid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_inst_loop_sequencer.sv
// Scoreboard bench for inst_loop_sequencer: stimulus pushes the expected address stream
// (-1 marks the done pulse); a negedge monitor pops and compares on each handshake/done.
module tb_inst_loop_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        clr;
    logic [1:0]  mode;
    logic [23:0] jmp;
    logic [23:0] endv;
    logic [23:0] cnt;
    logic        ready;
    logic [7:0]  pc;
    logic        valid;
    logic        busy;
    logic        done;
    logic        overrun;

    int checks;
    int failures;
    int exp_q[$];
    int seq[];
    int busy_cycles;

    inst_loop_sequencer dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .clr_i       (clr),
        .loop_mode_i (mode),
        .jump_addr_i (jmp),
        .end_addr_i  (endv),
        .loop_count_i(cnt),
        .inst_ready_i(ready),
        .inst_pc_o   (pc),
        .inst_valid_o(valid),
        .busy_o      (busy),
        .done_o      (done),
        .overrun_o   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compares every handshake and done pulse against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid && ready) begin
                if (exp_q.size() == 0) check("unexpected_pc", int'(pc), -2);
                else check("pc_stream", int'(pc), exp_q.pop_front());
            end
            if (done) begin
                if (exp_q.size() == 0) check("unexpected_done", 1, 0);
                else check("done_stream", -1, exp_q.pop_front());
            end
        end
    end

    task automatic push_seq(input int s[]);
        foreach (s[i]) exp_q.push_back(s[i]);
    endtask

    task automatic start_prog(input logic [1:0] m, input logic [23:0] j, input logic [23:0] e,
                              input logic [23:0] c);
        mode  = m;
        jmp   = j;
        endv  = e;
        cnt   = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Config is don't-care once running; scramble it to prove the snapshot is used.
        mode  = ~m;
        jmp   = ~j;
        endv  = ~e;
        cnt   = ~c;
    endtask

    task automatic wait_done(input string name, input int max_cycles, output int nbusy);
        bit seen;
        seen  = 1'b0;
        nbusy = 0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, int'(seen), 1);
        @(negedge clk);
        check({name, "_queue_drained"}, exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic run_prog(input string name, input logic [1:0] m, input logic [23:0] j,
                            input logic [23:0] e, input logic [23:0] c, input int s[]);
        push_seq(s);
        start_prog(m, j, e, c);
        wait_done(name, 600, busy_cycles);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        clr      = 1'b0;
        mode     = '0;
        jmp      = '0;
        endv     = '0;
        cnt      = '0;
        ready    = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", int'(pc), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_overrun", int'(overrun), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Straight line, 4 addresses, busy for exactly 4 cycles.
        seq = '{0, 1, 2, 3, -1};
        run_prog("linear", 2'd0, 24'h0, 24'h000003, 24'h000001, seq);
        check("linear_busy_cycles", busy_cycles, 4);

        seq = '{0, 1, 2, 1, 2, 1, 2, -1};
        run_prog("loop3", 2'd0, 24'h000001, 24'h000002, 24'h000003, seq);

        seq = '{0, 1, 2, 1, 2, 3, 0, 1, 2, 1, 2, 3, -1};
        run_prog("nested2", 2'd1, 24'h000001, 24'h000302, 24'h000202, seq);

        seq = '{0, 1, 2, 2, 0, 1, 2, 2, -1};
        run_prog("coincident", 2'd1, 24'h000002, 24'h000202, 24'h000202, seq);

        seq = '{0, 1, 1, 2, 3, 0, 1, 1, 2, 3, -1};
        run_prog("nested3", 2'd3, 24'h000001, 24'h030201, 24'h020102, seq);

        seq = '{0, 1, 2, -1};
        run_prog("count0", 2'd0, 24'h000001, 24'h000002, 24'h000000, seq);

        // Stall at PC=1 for 3 cycles.
        seq = '{0, 1, 2, 3, -1};
        push_seq(seq);
        start_prog(2'd0, 24'h0, 24'h000003, 24'h000001);
        @(posedge clk);
        #1;
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_pc_hold", int'(pc), 1);
            check("stall_valid", int'(valid), 1);
        end
        @(posedge clk);
        #1;
        ready = 1'b1;
        wait_done("stall", 50, busy_cycles);

        // Overrun: jump forward past the end address and run off the top.
        exp_q.delete();
        for (int a = 0; a <= 5; a++) exp_q.push_back(a);
        for (int a = 16; a <= 255; a++) exp_q.push_back(a);
        exp_q.push_back(-1);
        start_prog(2'd0, 24'h000010, 24'h000005, 24'h000002);
        wait_done("overrun", 600, busy_cycles);
        check("overrun_flag", int'(overrun), 1);
        check("overrun_pc_hold", int'(pc), 255);

        // Next start clears the sticky overrun.
        seq = '{0, 1, -1};
        run_prog("after_overrun", 2'd0, 24'h0, 24'h000001, 24'h000001, seq);
        check("overrun_cleared", int'(overrun), 0);

        // Clear at PC=2: back to idle with no done pulse.
        seq = '{0, 1, 2};
        push_seq(seq);
        start_prog(2'd0, 24'h000001, 24'h000002, 24'h000003);
        repeat (2) @(posedge clk);
        #1;
        check("clr_pre_pc", int'(pc), 2);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("clr_valid", int'(valid), 0);
        check("clr_busy", int'(busy), 0);
        check("clr_pc", int'(pc), 0);
        repeat (3) @(negedge clk);
        check("clr_queue_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
        seq = '{0, 1, 2, 1, 2, 1, 2, -1};
        run_prog("clr_replay", 2'd0, 24'h000001, 24'h000002, 24'h000003, seq);

        // Asynchronous reset mid-run.
        ready = 1'b0;
        start_prog(2'd0, 24'h0, 24'h000003, 24'h000001);
        @(negedge clk);
        check("arst_pre_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("arst_valid", int'(valid), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_pc", int'(pc), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready = 1'b1;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
